// File: rtl/key_entry_pkg.sv
// Shared types and constants for the key entry transmitter.
package key_entry_pkg;

    // Entry sequence progress.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTERING = 2'd1,
        FULL     = 2'd2
    } state_t;

    // One stream beat: digit payload plus sequence terminator flag.
    typedef struct packed {
        logic       last;
        logic [3:0] data;
    } beat_t;

    // Payload carried by the terminator beat.
    localparam logic [3:0] TERM_DATA = 4'h0;

endpackage

// File: rtl/key_entry_tx_debouncer.sv
// Two-flop synchroniser, level debouncer and press pulse for one
// active-low push-button.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic srst,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;
    logic             level;

    // Synchronised level, converted to active-high (1 = pressed).
    assign level = ~sync_reg[1];
    assign press = press_reg;

    // Synchronise, require a run of differing samples before flipping the
    // stable level, and pulse once on a released->pressed flip.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg   <= 2'b11;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
            press_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], key_n};
            press_reg <= 1'b0;
            if (level == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_reg <= level;
                cnt_reg    <= '0;
                press_reg  <= level;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_entry_tx.sv
// Key entry transmitter: debounced entry/submit buttons build digit
// sequences that are queued and streamed out over valid/ready.
module key_entry_tx #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int MAX_LEN         = 4,
    parameter int DEPTH           = 8
) (
    input  logic       clk,
    input  logic       system_reset,
    input  logic       entry_key_n,
    input  logic       submit_key_n,
    input  logic [3:0] bits,
    output logic [3:0] digit_data,
    output logic       digit_last,
    output logic       digit_valid,
    input  logic       digit_ready,
    output logic [2:0] entry_count,
    output logic       overflow,
    output logic       busy
);
    import key_entry_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [2:0]       MAX_CNT  = 3'(MAX_LEN);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // Key events: index 0 = entry, index 1 = submit.
    logic [1:0] key_n;
    logic [1:0] press;

    assign key_n = {submit_key_n, entry_key_n};

    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debouncer (
            .clk   (clk),
            .srst  (system_reset),
            .key_n (key_n[gi]),
            .press (press[gi])
        );
    end

    logic entry_ev;
    logic submit_ev;
    assign entry_ev  = press[0];
    assign submit_ev = press[1];

    state_t     state_reg, state_next;
    logic [2:0] count_reg, count_next;
    logic       ovf_reg, ovf_next;
    logic       busy_reg;

    beat_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg, occ_next;
    logic             fifo_full;
    logic             push_en;
    beat_t            push_beat;
    logic             pop;
    beat_t            head;

    assign fifo_full = (occ_reg == OCC_FULL);

    // Sequence control: submit wins over a coincident entry press; drops
    // leave state untouched so the user can retry.
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        ovf_next       = ovf_reg;
        push_en        = 1'b0;
        push_beat.last = 1'b0;
        push_beat.data = bits;
        if (submit_ev) begin
            if (state_reg != IDLE && !fifo_full) begin
                push_en        = 1'b1;
                push_beat.last = 1'b1;
                push_beat.data = TERM_DATA;
                count_next     = '0;
                ovf_next       = 1'b0;
                state_next     = IDLE;
            end
        end else if (entry_ev) begin
            if (state_reg != FULL && !fifo_full) begin
                push_en    = 1'b1;
                count_next = count_reg + 3'd1;
                state_next = (count_next == MAX_CNT) ? FULL : ENTERING;
            end else begin
                ovf_next = 1'b1;
            end
        end
    end

    // Sequence state registers.
    always_ff @(posedge clk) begin
        if (system_reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Beat storage; contents need no reset because valid gates the output.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= push_beat;
        end
    end

    assign head        = mem[rd_ptr_reg];
    assign digit_valid = (occ_reg != '0);
    assign digit_data  = digit_valid ? head.data : 4'h0;
    assign digit_last  = digit_valid & head.last;
    assign pop         = digit_valid & digit_ready;

    // Occupancy follows push/pop; simultaneous push and pop cancel.
    always_comb begin
        occ_next = occ_reg;
        case ({push_en, pop})
            2'b10:   occ_next = occ_reg + OCC_W'(1);
            2'b01:   occ_next = occ_reg - OCC_W'(1);
            default: occ_next = occ_reg;
        endcase
    end

    // FIFO pointers, occupancy and registered busy flag.
    always_ff @(posedge clk) begin
        if (system_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            busy_reg   <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
            end
            occ_reg  <= occ_next;
            busy_reg <= (occ_next != '0);
        end
    end

    assign entry_count = count_reg;
    assign overflow    = ovf_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_key_entry_tx.sv
// Directed bench for key_entry_tx with a sequence-level scoreboard model.
module tb_key_entry_tx;

    localparam int D  = 4;
    localparam int CW = 3;
    localparam int ML = 4;
    localparam int DP = 8;

    logic       clk = 1'b0;
    logic       system_reset = 1'b1;
    logic       entry_key_n = 1'b1;
    logic       submit_key_n = 1'b1;
    logic [3:0] bits = 4'h0;
    logic       digit_ready = 1'b1;
    logic [3:0] digit_data;
    logic       digit_last;
    logic       digit_valid;
    logic [2:0] entry_count;
    logic       overflow;
    logic       busy;

    key_entry_tx #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW),
        .MAX_LEN         (ML),
        .DEPTH           (DP)
    ) dut (
        .clk          (clk),
        .system_reset (system_reset),
        .entry_key_n  (entry_key_n),
        .submit_key_n (submit_key_n),
        .bits         (bits),
        .digit_data   (digit_data),
        .digit_last   (digit_last),
        .digit_valid  (digit_valid),
        .digit_ready  (digit_ready),
        .entry_count  (entry_count),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: expected beats ({last,data}) in order, digits pending, sticky flag.
    logic [4:0] sb[$];
    logic [4:0] seen[$];
    int         m_cnt = 0;
    int         m_ovf = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_entry(input logic [3:0] b);
        if (m_cnt < ML && sb.size() < DP) begin
            sb.push_back({1'b0, b});
            m_cnt++;
        end else begin
            m_ovf = 1;
        end
    endfunction

    function automatic void model_submit();
        if (m_cnt != 0 && sb.size() < DP) begin
            sb.push_back(5'h10);
            m_cnt = 0;
            m_ovf = 0;
        end
    endfunction

    // Compare process: every handshake against the scoreboard, stall stability.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [4:0] prev_beat  = 5'h0;

    always @(negedge clk) begin
        if (system_reset) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", int'(digit_valid), 1);
                check("hold_beat", int'({digit_last, digit_data}), int'(prev_beat));
            end
            check("busy_vs_valid", int'(busy), int'(digit_valid));
            if (digit_valid && digit_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h, expected no beat", {digit_last, digit_data});
                end else begin
                    check("beat", int'({digit_last, digit_data}), int'(sb.pop_front()));
                end
                seen.push_back({digit_last, digit_data});
            end
            prev_valid = digit_valid;
            prev_ready = digit_ready;
            prev_beat  = {digit_last, digit_data};
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle_checks(input string name);
        check({name, "_count"}, int'(entry_count), m_cnt);
        check({name, "_overflow"}, int'(overflow), m_ovf);
        check({name, "_busy"}, int'(busy), int'(sb.size() != 0));
    endtask

    task automatic press_entry(input logic [3:0] b, input bit measure);
        int n;
        bits = b;
        model_entry(b);
        entry_key_n = 1'b0;
        if (measure) begin
            n = 0;
            while (!digit_valid && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("press_latency", n, D + 3);
        end
        wait_cycles(D + 6);
        entry_key_n = 1'b1;
        wait_cycles(D + 6);
        settle_checks("entry");
    endtask

    task automatic press_submit();
        model_submit();
        submit_key_n = 1'b0;
        wait_cycles(D + 6);
        submit_key_n = 1'b1;
        wait_cycles(D + 6);
        settle_checks("submit");
    endtask

    task automatic press_both(input logic [3:0] b);
        bits = b;
        model_submit();
        entry_key_n  = 1'b0;
        submit_key_n = 1'b0;
        wait_cycles(D + 6);
        entry_key_n  = 1'b1;
        submit_key_n = 1'b1;
        wait_cycles(D + 6);
        settle_checks("both");
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drain_left"}, sb.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] exp_lit [5];
        logic [3:0] clean_bits [4];
        exp_lit    = '{5'h03, 5'h07, 5'h01, 5'h09, 5'h10};
        clean_bits = '{4'd3, 4'd7, 4'd1, 4'd9};

        // Reset state
        wait_cycles(3);
        system_reset = 1'b0;
        #1;
        check("rst_valid", int'(digit_valid), 0);
        check("rst_data", int'(digit_data), 0);
        check("rst_last", int'(digit_last), 0);
        check("rst_count", int'(entry_count), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_busy", int'(busy), 0);
        wait_cycles(2);

        // Clean sequence 3,7,1,9 then submit
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            press_entry(clean_bits[i], i == 0);
            check("clean_count_lit", int'(entry_count), i + 1);
        end
        press_submit();
        check("clean_count_end", int'(entry_count), 0);
        check("clean_overflow", int'(overflow), 0);
        check("clean_nbeats", seen.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < seen.size()) check("clean_beat_lit", int'(seen[i]), int'(exp_lit[i]));
        end

        // Bounce: toggle every 2 cycles for 20 cycles, then hold low
        seen.delete();
        bits = 4'd5;
        model_entry(4'd5);
        for (int i = 0; i < 10; i++) begin
            entry_key_n = ~entry_key_n;
            wait_cycles(2);
        end
        entry_key_n = 1'b0;
        wait_cycles(10);
        entry_key_n = 1'b1;
        wait_cycles(D + 6);
        settle_checks("bounce");
        check("bounce_nbeats", seen.size(), 1);
        press_submit();

        // Overflow: 5 entries, 5th dropped, submit clears
        for (int i = 0; i < 5; i++) press_entry(4'(i + 2), 1'b0);
        check("ovf_set_lit", int'(overflow), 1);
        check("ovf_count_lit", int'(entry_count), 4);
        press_submit();
        check("ovf_cleared_lit", int'(overflow), 0);

        // Submit in IDLE gives no beat
        seen.delete();
        press_submit();
        check("idle_submit_nbeats", seen.size(), 0);

        // Entry and submit in the same cycle with count=2
        press_entry(4'd8, 1'b0);
        press_entry(4'd6, 1'b0);
        seen.delete();
        press_both(4'd4);
        check("both_count_lit", int'(entry_count), 0);
        check("both_nbeats", seen.size(), 1);
        if (seen.size() > 0) check("both_beat_lit", int'(seen[0]), 5'h10);

        // Backpressure: two 3-digit sequences fill the FIFO
        digit_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 3; i++) press_entry(4'(3 * s + i + 1), 1'b0);
            press_submit();
        end
        check("bp_busy_lit", int'(busy), 1);
        check("bp_valid_lit", int'(digit_valid), 1);
        check("bp_head_lit", int'(digit_data), 1);
        press_entry(4'd7, 1'b0);
        check("bp_drop_ovf_lit", int'(overflow), 1);
        check("bp_drop_count_lit", int'(entry_count), 0);
        digit_ready = 1'b1;
        wait_drain("bp");
        wait_cycles(2);
        check("bp_busy_after", int'(busy), 0);

        // Reset mid-operation with 3 beats queued
        digit_ready = 1'b0;
        for (int i = 0; i < 3; i++) press_entry(4'(i + 10), 1'b0);
        check("mid_valid_before", int'(digit_valid), 1);
        system_reset = 1'b1;
        sb.delete();
        m_cnt = 0;
        m_ovf = 0;
        @(posedge clk);
        #1;
        system_reset = 1'b0;
        check("mid_valid", int'(digit_valid), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_count", int'(entry_count), 0);
        check("mid_overflow", int'(overflow), 0);
        digit_ready = 1'b1;
        seen.delete();
        wait_cycles(20);
        check("mid_stale_beats", seen.size(), 0);

        wait_cycles(5);
        check("final_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
